threshold_hysteresis_det: RTL and testbench

Threshold detector with hysteresis and debounce. It compares a 16-bit unsigned sample stream against the high and low thresholds from the i1Thresholds register block (`i1Thresholds_highThreshold_o` and `i1Thresholds_lowThreshold_o`) and holds an above/below state. It emits one-cycle rise and fall events and keeps a saturating crossing counter for software. It sits directly downstream of the register block, between that block and the interrupt and monitoring logic.

---
 rtl/thr_det_pkg.sv | 16 +
 rtl/thr_debounce.sv | 44 ++++
 rtl/threshold_hysteresis_det.sv | 115 +++++++++++
 tb/tb_threshold_hysteresis_det.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/thr_det_pkg.sv
// Shared types and helpers for the threshold/hysteresis detector.
package thr_det_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic {
    ST_BELOW = 1'b0,
    ST_ABOVE = 1'b1
  } state_e;

  // Debounce counter width; sized to hold DEBOUNCE_LEN.
  function automatic int unsigned deb_cnt_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/thr_debounce.sv
// Debounce counter: counts consecutive valid qualifying samples and flags the
// sample that completes the run.
module thr_debounce
  import thr_det_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic qual_i,
  input  logic hold_i,
  output logic hit_o
);

  localparam int unsigned CntW = deb_cnt_w(DEBOUNCE_LEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(DEBOUNCE_LEN - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  // A config error masks every sample, so no hit can fire while held.
  assign hit_o = valid_i & qual_i & ~hold_i & (r_cnt == LastCnt);

  // Next count: hold/hit clear, valid qualifying increments, valid miss clears.
  always_comb begin
    w_cnt_d = r_cnt;
    if (hold_i || hit_o) begin
      w_cnt_d = '0;
    end else if (valid_i) begin
      w_cnt_d = qual_i ? r_cnt + 1'b1 : '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/threshold_hysteresis_det.sv
// Threshold detector with hysteresis, debounce, rise/fall events and a
// saturating crossing counter. All outputs are registered.
module threshold_hysteresis_det
  import thr_det_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LEN = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [SAMPLE_W-1:0] high_threshold_i,
  input  logic [SAMPLE_W-1:0] low_threshold_i,
  input  logic                cnt_clr_i,
  output logic                above_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic [CNT_W-1:0]    cross_cnt_o,
  output logic                cfg_err_o
);

  logic       r_s1_valid;
  logic       r_ge_high;
  logic       r_le_low;
  logic       r_cfg_err;
  state_e     r_state;
  state_e     w_state_d;
  logic       r_rise;
  logic       r_fall;
  logic       w_rise_d;
  logic       w_fall_d;
  logic       w_qual;
  logic       w_hit;
  logic [CNT_W-1:0] r_cross;

  // Stage 1: register comparisons; thresholds are re-read every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_ge_high  <= 1'b0;
      r_le_low   <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_s1_valid <= sample_valid_i;
      r_ge_high  <= (sample_i >= high_threshold_i);
      r_le_low   <= (sample_i <= low_threshold_i);
      r_cfg_err  <= (low_threshold_i > high_threshold_i);
    end
  end

  // Qualifying condition depends on which threshold leaves the current state.
  assign w_qual = (r_state == ST_BELOW) ? r_ge_high : r_le_low;

  thr_debounce #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN)
  ) u_debounce (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (r_s1_valid),
    .qual_i  (w_qual),
    .hold_i  (r_cfg_err),
    .hit_o   (w_hit)
  );

  // Next state and event pulses.
  always_comb begin
    w_state_d = r_state;
    w_rise_d  = 1'b0;
    w_fall_d  = 1'b0;
    if (w_hit) begin
      unique case (r_state)
        ST_BELOW: begin
          w_state_d = ST_ABOVE;
          w_rise_d  = 1'b1;
        end
        ST_ABOVE: begin
          w_state_d = ST_BELOW;
          w_fall_d  = 1'b1;
        end
      endcase
    end
  end

  // State register and registered event pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_BELOW;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
    end
  end

  // Saturating crossing counter; clear has priority over increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cross <= '0;
    end else if (cnt_clr_i) begin
      r_cross <= '0;
    end else if (r_rise && (r_cross != '1)) begin
      r_cross <= r_cross + 1'b1;
    end
  end

  assign above_o     = (r_state == ST_ABOVE);
  assign rise_o      = r_rise;
  assign fall_o      = r_fall;
  assign cross_cnt_o = r_cross;
  assign cfg_err_o   = r_cfg_err;

endmodule

// File: tb/tb_threshold_hysteresis_det.sv
// Directed self-checking bench for threshold_hysteresis_det.
// A narrow crossing counter keeps the saturation check short.
module tb_threshold_hysteresis_det;

  localparam int unsigned DebLen = 4;
  localparam int unsigned CntW   = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            sample_valid_i;
  logic [15:0]     sample_i;
  logic [15:0]     high_threshold_i;
  logic [15:0]     low_threshold_i;
  logic            cnt_clr_i;
  logic            above_o;
  logic            rise_o;
  logic            fall_o;
  logic [CntW-1:0] cross_cnt_o;
  logic            cfg_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rise   = 0;
  int n_fall   = 0;
  int rise_ref;
  int fall_ref;

  threshold_hysteresis_det #(
    .DEBOUNCE_LEN (DebLen),
    .CNT_W        (CntW)
  ) u_dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .sample_valid_i   (sample_valid_i),
    .sample_i         (sample_i),
    .high_threshold_i (high_threshold_i),
    .low_threshold_i  (low_threshold_i),
    .cnt_clr_i        (cnt_clr_i),
    .above_o          (above_o),
    .rise_o           (rise_o),
    .fall_o           (fall_o),
    .cross_cnt_o      (cross_cnt_o),
    .cfg_err_o        (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Event tally, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rise_o) n_rise++;
    if (fall_o) n_fall++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [15:0] s);
    sample_valid_i = 1'b1;
    sample_i       = s;
    tick();
  endtask

  task automatic send_n(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) send(s);
  endtask

  task automatic idle(input int n);
    sample_valid_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_i            = 1'b1;
    sample_valid_i   = 1'b0;
    sample_i         = '0;
    high_threshold_i = 16'd1000;
    low_threshold_i  = 16'd500;
    cnt_clr_i        = 1'b0;
    idle(2);
    check_val("rst_above", above_o, 0);
    check_val("rst_rise", rise_o, 0);
    check_val("rst_fall", fall_o, 0);
    check_val("rst_cnt", cross_cnt_o, 0);
    check_val("rst_cfg", cfg_err_o, 0);
    rst_i = 1'b0;
    idle(1);

    // Rise: exactly two cycles after the 4th sample.
    send_n(16'd1000, 4);
    check_val("rise_early", rise_o, 0);
    idle(1);
    check_val("rise_pulse", rise_o, 1);
    check_val("rise_above", above_o, 1);
    idle(1);
    check_val("rise_once", rise_o, 0);
    check_val("rise_cnt", cross_cnt_o, 1);

    // Hysteresis: 700 is between thresholds, never falls.
    fall_ref = n_fall;
    send_n(16'd700, 10);
    idle(2);
    check_val("hyst_nofall", n_fall - fall_ref, 0);
    check_val("hyst_above", above_o, 1);
    send_n(16'd500, 4);
    idle(1);
    check_val("fall_pulse", fall_o, 1);
    check_val("fall_above", above_o, 0);
    idle(1);
    check_val("fall_cnt_kept", cross_cnt_o, 1);

    // Debounce restart on a non-qualifying sample.
    rise_ref = n_rise;
    send_n(16'd1200, 3);
    send(16'd900);
    send_n(16'd1200, 3);
    idle(3);
    check_val("deb_norise", n_rise - rise_ref, 0);
    send(16'd1200);
    idle(2);
    check_val("deb_rise", n_rise - rise_ref, 1);
    check_val("deb_cnt", cross_cnt_o, 2);

    // Gaps between valid samples do not break the run.
    send(16'd500);
    idle(1);
    send(16'd500);
    idle(2);
    send(16'd500);
    idle(1);
    check_val("gap_early", above_o, 1);
    send(16'd500);
    idle(1);
    check_val("gap_fall", fall_o, 1);
    check_val("gap_above", above_o, 0);

    // Config error freezes everything.
    rise_ref = n_rise;
    low_threshold_i = 16'd2000;
    idle(1);
    check_val("cfg_set", cfg_err_o, 1);
    send_n(16'd3000, 8);
    idle(2);
    check_val("cfg_norise", n_rise - rise_ref, 0);
    check_val("cfg_above", above_o, 0);
    low_threshold_i = 16'd500;
    idle(1);
    check_val("cfg_clr", cfg_err_o, 0);
    send_n(16'd1200, 3);
    idle(3);
    check_val("cfg_restart", n_rise - rise_ref, 0);
    send(16'd1200);
    idle(1);
    check_val("cfg_rise", rise_o, 1);
    idle(1);
    check_val("cfg_cnt", cross_cnt_o, 3);

    // Clear coincident with rise wins.
    send_n(16'd500, 4);
    idle(2);
    send_n(16'd1200, 4);
    idle(1);
    check_val("clr_rise", rise_o, 1);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    check_val("clr_wins", cross_cnt_o, 0);

    // Saturation of the crossing counter.
    for (int k = 0; k < 15; k++) begin
      send_n(16'd500, 4);
      send_n(16'd1200, 4);
      idle(2);
    end
    check_val("sat_reach", cross_cnt_o, 15);
    for (int k = 0; k < 2; k++) begin
      send_n(16'd500, 4);
      send_n(16'd1200, 4);
      idle(2);
    end
    check_val("sat_hold", cross_cnt_o, 15);
    check_val("sat_above", above_o, 1);

    // Reset mid-debounce.
    send_n(16'd500, 2);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    check_val("mid_rst_above", above_o, 0);
    check_val("mid_rst_cnt", cross_cnt_o, 0);
    check_val("mid_rst_rise", rise_o, 0);
    check_val("mid_rst_fall", fall_o, 0);
    rise_ref = n_rise;
    send_n(16'd1200, 2);
    idle(3);
    check_val("post_rst_norise", n_rise - rise_ref, 0);
    send_n(16'd1200, 4);
    idle(2);
    check_val("post_rst_rise", n_rise - rise_ref, 1);
    check_val("post_rst_cnt", cross_cnt_o, 1);

    // Equal thresholds: a sample equal to both qualifies either way.
    high_threshold_i = 16'd800;
    low_threshold_i  = 16'd800;
    fall_ref = n_fall;
    rise_ref = n_rise;
    send_n(16'd800, 4);
    idle(2);
    check_val("eq_fall", n_fall - fall_ref, 1);
    check_val("eq_cfg", cfg_err_o, 0);
    send_n(16'd800, 4);
    idle(2);
    check_val("eq_rise", n_rise - rise_ref, 1);
    check_val("eq_above", above_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
